ram_multiport: RTL
==================

# ram_multiport

Parametrised multi-port word memory, the successor to the single 32-bit shared register used between the calculator's operand and result paths. It holds DEPTH words of WIDTH bits and provides one read/write port (A), one read-only port (R) and one write-only port (W), with fixed write priority. It adds a reset-driven clear sequencer with a busy indication and a registered write-collision flag. It sits between the ALU result path (port W) and the control/display logic (ports A and R).

## Interface
- WIDTH, 32, data word width (≥ 1)
- DEPTH, 16, number of words (≥ 2; need not be a power of two)
- INIT_ON_RESET, 1, 1: reset clears every word; 0: reset only resets control state, contents retained
- ADDR_W, $clog2(DEPTH), derived, not overridable

Ports:
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  synchronous, active-high reset, sampled on the falling edge of clk
- ce_a  in  1  port A enable
- we_a  in  1  port A write enable, effective only with ce_a
- addr_a  in  ADDR_W  port A address
- di_a  in  WIDTH  port A write data
- do_a  out  WIDTH  port A read data
- ce_r  in  1  port R enable
- addr_r  in  ADDR_W  port R address
- do_r  out  WIDTH  port R read data
- ce_w  in  1  port W enable
- we_w  in  1  port W write enable, effective only with ce_w
- addr_w  in  ADDR_W  port W address
- di_w  in  WIDTH  port W write data
- busy  out  1  clear sequence in progress
- wr_collision  out  1  one-cycle flag: A and W wrote the same address on the last falling edge

## Operation
- Two states: CLEAR and READY.
- While rst is high:
  - state goes to CLEAR if INIT_ON_RESET=1, otherwise READY.
  - clr_ptr=0, wr_collision=0.
  - No writes occur.
- CLEAR:
  - Each falling edge with rst low writes 0 to mem[clr_ptr] and increments clr_ptr.
  - After the edge that writes word DEPTH-1, the state goes to READY.
  - Port writes are ignored. busy=1.
- READY: busy=0. Writes are enabled:
  - Port A writes di_a to mem[addr_a] when ce_a&we_a.
  - Port W writes di_w to mem[addr_w] when ce_w&we_w.
  - If both write the same address on the same edge, port W wins and wr_collision=1 for the following cycle. Otherwise wr_collision=0.
  - Writes to different addresses on the same edge both take effect.
- Reads are asynchronous from the array:
  - do_a = mem[addr_a] when ce_a and not busy, else 0.
  - do_r = mem[addr_r] when ce_r and not busy, else 0.
  - Outputs are driven 0, never high-impedance.
- Out-of-range addresses (≥ DEPTH) are ignored on write and read as 0.
- A port A read during a port A write returns the old word until the falling edge, then the new word.

## Timing
- Reset values: busy=1 (INIT_ON_RESET=1) or 0; wr_collision=0; do_a=do_r=0 while busy, or while the corresponding ce is low.
- Write latency: data visible on any read port immediately after the falling edge that writes it, so it is stable for the next rising edge.
- Clear duration: busy is high for exactly DEPTH falling edges after the first edge with rst low.
- rst asserted mid-clear restarts the clear at clr_ptr=0.
- rst asserted in READY with INIT_ON_RESET=0: contents are preserved.
- wr_collision is registered: high from the colliding falling edge to the next falling edge.

## Structure
- Package ram_pkg contains:
  - the state enum (CLEAR, READY)
  - the address-width function clog2 with a minimum of 1
- One sub-module, ram_clear_seq, holds the state register, clr_ptr and busy. It outputs the clear-write strobe and address.
- The array, write arbitration, collision register and read muxes are in ram_multiport.

## Test plan
- Reset clear: WIDTH=32, DEPTH=16, preload mem via writes, pulse rst 1 cycle -> busy high 16 falling edges, then every address reads 0 on do_a and do_r.
- Priority: in READY, same edge A writes 0x1111_1111 and W writes 0x2222_2222 to addr 5 -> mem[5]=0x2222_2222, wr_collision=1 for one cycle, then 0.
- Dual write: A writes 0xAAAA_0001 to addr 2 and W writes 0xBBBB_0003 to addr 3 on the same edge -> both stored, wr_collision stays 0.
- Enables and range: ce_r=0 -> do_r=0; DEPTH=12, write addr 13 -> no change to any word, read addr 13 returns 0.
- Busy gating: writes issued during CLEAR are discarded. rst reasserted at clr_ptr=7 -> busy stays high a further 16 edges after release.
- INIT_ON_RESET=0: write 0xDEAD_BEEF to addr 0, pulse rst -> busy never rises, addr 0 still reads 0xDEAD_BEEF.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-port word memory.
package ram_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    // Address width for n words, never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every word after reset, holding busy until done.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter bit INIT_ON_RESET = 1'b1,
    parameter int ADDR_W        = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nx;

    always_ff @(negedge clk) begin
        if (rst) begin
            state <= INIT_ON_RESET ? CLEAR : READY;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        clr_we   = 1'b0;
        if (state == CLEAR) begin
            clr_we = !rst;
            ptr_nx = ptr + 1'b1;
            if (ptr == LAST) begin
                state_nx = READY;
                ptr_nx   = '0;
            end
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/ram_multiport.sv
// Word memory with read/write port A, read port R and write port W.
module ram_multiport
    import ram_pkg::*;
#(
    parameter  int WIDTH         = 32,
    parameter  int DEPTH         = 16,
    parameter  bit INIT_ON_RESET = 1'b1,
    localparam int ADDR_W        = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  di_a,
    output logic [WIDTH-1:0]  do_a,
    input  logic              ce_r,
    input  logic [ADDR_W-1:0] addr_r,
    output logic [WIDTH-1:0]  do_r,
    input  logic              ce_w,
    input  logic              we_w,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [WIDTH-1:0]  di_w,
    output logic              busy,
    output logic              wr_collision
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              in_a;
    logic              in_r;
    logic              in_w;
    logic              wa;
    logic              ww;

    ram_clear_seq #(
        .DEPTH        (DEPTH),
        .INIT_ON_RESET(INIT_ON_RESET),
        .ADDR_W       (ADDR_W)
    ) u_seq (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    assign in_a = 32'(addr_a) < DEPTH;
    assign in_r = 32'(addr_r) < DEPTH;
    assign in_w = 32'(addr_w) < DEPTH;

    assign wa = ce_a && we_a && in_a && !busy && !rst;
    assign ww = ce_w && we_w && in_w && !busy && !rst;

    // W is assigned last so it overrides A on a shared address.
    always_ff @(negedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wa) mem[addr_a] <= di_a;
            if (ww) mem[addr_w] <= di_w;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) wr_collision <= 1'b0;
        else     wr_collision <= wa && ww && (addr_a == addr_w);
    end

    assign do_a = (ce_a && !busy && in_a) ? mem[addr_a] : '0;
    assign do_r = (ce_r && !busy && in_r) ? mem[addr_r] : '0;

endmodule
